// File: rtl/add_round_key_stage.sv
// AES AddRoundKey pipeline stage: (final ? ShiftRows : MixColumns) ^ key, registered,
// with valid/ready flow control through a main + skid register pair. Optional: ARK_PARITY_EN.
module add_round_key_stage #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mc,
    input  logic [DATA_W-1:0] in_sr,
    input  logic              in_last,
    input  logic [DATA_W-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
`ifdef ARK_PARITY_EN
    output logic [15:0]       out_parity,
`endif
    output logic [CNT_W-1:0]  blk_count
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                main_last_q, main_last_d;
    logic                skid_last_q, skid_last_d;
    logic [CNT_W-1:0]    blk_count_q, blk_count_d;
    logic [DATA_W-1:0]   cap_data;
    logic                accept;
    logic                fire;
`ifdef ARK_PARITY_EN
    logic [15:0]         main_par_q, main_par_d;
    logic [15:0]         skid_par_q, skid_par_d;
    logic [15:0]         cap_par;
`endif

    // in_ready decodes registered state only, so out_ready never reaches it combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign cap_data  = (in_last ? in_sr : in_mc) ^ in_key;

`ifdef ARK_PARITY_EN
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            cap_par[i] = ^cap_data[8*i +: 8];
        end
    end
`endif

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d     = state_q;
        main_data_d = main_data_q;
        main_last_d = main_last_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        blk_count_d = blk_count_q;
`ifdef ARK_PARITY_EN
        main_par_d  = main_par_q;
        skid_par_d  = skid_par_q;
`endif

        if (fire && main_last_q) begin
            blk_count_d = blk_count_q + CNT_W'(1);
        end

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = cap_data;
                    main_last_d = in_last;
`ifdef ARK_PARITY_EN
                    main_par_d  = cap_par;
`endif
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    main_data_d = cap_data;
                    main_last_d = in_last;
`ifdef ARK_PARITY_EN
                    main_par_d  = cap_par;
`endif
                end else if (fire) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    // Main is stalled, so the new beat parks in the skid register.
                    skid_data_d = cap_data;
                    skid_last_d = in_last;
`ifdef ARK_PARITY_EN
                    skid_par_d  = cap_par;
`endif
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (fire) begin
                    main_data_d = skid_data_q;
                    main_last_d = skid_last_q;
`ifdef ARK_PARITY_EN
                    main_par_d  = skid_par_q;
`endif
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: data registers are reset too, because out_data must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_last_q <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            blk_count_q <= '0;
`ifdef ARK_PARITY_EN
            main_par_q  <= '0;
            skid_par_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_last_q <= main_last_d;
            skid_data_q <= skid_data_d;
            skid_last_q <= skid_last_d;
            blk_count_q <= blk_count_d;
`ifdef ARK_PARITY_EN
            main_par_q  <= main_par_d;
            skid_par_q  <= skid_par_d;
`endif
        end
    end

    assign out_data  = main_data_q;
    assign out_last  = main_last_q;
    assign blk_count = blk_count_q;
`ifdef ARK_PARITY_EN
    assign out_parity = main_par_q;
`endif

endmodule
